// File: rtl/rr_arbiter8.sv
// Round-robin arbiter: 8 requesters share one resource, grant held until released.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter8 #(
    parameter int N_REQ    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic                     done,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     grant_valid,
    output logic                     timeout
);

    localparam int IDW = $clog2(N_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDW-1:0]     gid_q, gid_d;
    logic [IDW-1:0]     rel_ptr;
    logic               nat_rel;
    logic               force_rel;
    logic               new_grant;

    // First set request searching upward from p, wrapping at N_REQ.
    function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDW-1:0]   p);
        logic [IDW-1:0] idx;
        rr_pick = p;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = p + IDW'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    function automatic logic [N_REQ-1:0] to_onehot(input logic [IDW-1:0] id);
        to_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << id;
    endfunction

    assign nat_rel = done | ~req[gid_q];
    assign rel_ptr = gid_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        gid_d     = gid_q;
        new_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gid_d     = rr_pick(req, ptr_q);
                    grant_d   = to_onehot(gid_d);
                    state_d   = BUSY;
                    new_grant = 1'b1;
                end
            end
            BUSY: begin
                if (nat_rel | force_rel) begin
                    // Releasing owner becomes lowest priority; regrant with no bubble.
                    ptr_d = rel_ptr;
                    if (|req) begin
                        gid_d     = rr_pick(req, rel_ptr);
                        grant_d   = to_onehot(gid_d);
                        new_grant = 1'b1;
                    end else begin
                        gid_d   = '0;
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                gid_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q;

    // A natural release on the same edge wins over the forced one.
    assign force_rel = (state_q == BUSY) & (hold_cnt_q == HOLD_LAST) & ~nat_rel;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (new_grant) begin
            hold_cnt_d = '0;
        end else if (state_q == BUSY && !nat_rel && !force_rel) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= force_rel;
        end
    end

    assign timeout = timeout_q;
`else
    logic [7:0] unused_hold;
    logic       unused_new_grant;

    assign force_rel        = 1'b0;
    assign timeout          = 1'b0;
    assign unused_hold      = 8'(MAX_HOLD - 1);
    assign unused_new_grant = new_grant;
`endif

    assign grant       = grant_q;
    assign grant_id    = gid_q;
    assign grant_valid = |grant_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios plus random traffic against a
// behavioural owner/pointer model.
module tb_rr_arbiter8;

`ifdef ARB_TIMEOUT_EN
    localparam int MH = 4;
    localparam bit TMO = 1'b1;
`else
    localparam int MH = 16;
    localparam bit TMO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // model: owner index (-1 none), priority pointer, cycles held, timeout pulse
    int m_own  = -1;
    int m_ptr  = 0;
    int m_hold = 0;
    bit m_to   = 1'b0;

    rr_arbiter8 #(.N_REQ(8), .MAX_HOLD(MH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .grant_id   (grant_id),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int win(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    task automatic model_edge(input logic rn, input logic [7:0] r, input logic d);
        bit nat, frc;
        if (!rn) begin
            m_own = -1; m_ptr = 0; m_hold = 0; m_to = 1'b0;
        end else if (m_own < 0) begin
            m_to = 1'b0;
            if (r != 0) begin
                m_own = win(r, m_ptr);
                m_hold = 0;
            end
        end else begin
            nat  = d || !r[m_own];
            frc  = TMO && (m_hold == MH - 1) && !nat;
            m_to = frc;
            if (nat || frc) begin
                m_ptr = (m_own + 1) % 8;
                m_own = (r != 0) ? win(r, m_ptr) : -1;
                m_hold = 0;
            end else begin
                m_hold++;
            end
        end
    endtask

    // Apply inputs for one clock, advance the model, compare #1 after the edge.
    task automatic step(input logic rn, input logic [7:0] r, input logic d);
        rst_n = rn; req = r; done = d;
        @(posedge clk);
        model_edge(rn, r, d);
        #1;
        chk("grant",       {24'd0, grant},      (m_own < 0) ? 32'd0 : (32'd1 << m_own));
        chk("grant_id",    {29'd0, grant_id},   (m_own < 0) ? 32'd0 : 32'(m_own));
        chk("grant_valid", {31'd0, grant_valid}, (m_own < 0) ? 32'd0 : 32'd1);
        chk("timeout",     {31'd0, timeout},    {31'd0, m_to});
    endtask

    initial begin
        // reset with all requests pending
        step(1'b0, 8'hFF, 1'b0);
        step(1'b0, 8'hFF, 1'b0);
        chk("rst_grant", {24'd0, grant}, 32'h00);
        chk("rst_id", {29'd0, grant_id}, 32'd0);
        chk("rst_valid", {31'd0, grant_valid}, 32'd0);
        step(1'b1, 8'hFF, 1'b0);
        chk("first_grant", {24'd0, grant}, 32'h01);

        // rotation: done every 3rd cycle
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'hFF, 1'b0);
            step(1'b1, 8'hFF, 1'b0);
            step(1'b1, 8'hFF, 1'b1);
            chk("rotate_id", {29'd0, grant_id}, 32'((i + 1) % 8));
        end

        // lock and wrap past 7
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h40, 1'b0);
        chk("lock_id6", {29'd0, grant_id}, 32'd6);
        step(1'b1, 8'h49, 1'b0);
        chk("lock_hold", {24'd0, grant}, 32'h40);
        step(1'b1, 8'h41, 1'b1);
        chk("wrap_id0", {29'd0, grant_id}, 32'd0);

        // owner drops request with nobody else waiting
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h04, 1'b0);
        chk("drop_own2", {29'd0, grant_id}, 32'd2);
        step(1'b1, 8'h00, 1'b0);
        chk("drop_idle", {31'd0, grant_valid}, 32'd0);
        step(1'b1, 8'h0C, 1'b0);
        chk("drop_ptr3", {29'd0, grant_id}, 32'd3);

        // sole requester regranted seamlessly
        step(1'b1, 8'h10, 1'b0);
        chk("sole_id4", {29'd0, grant_id}, 32'd4);
        step(1'b1, 8'h10, 1'b1);
        chk("sole_regrant", {24'd0, grant}, 32'h10);
        step(1'b1, 8'h10, 1'b0);
        chk("sole_keep", {24'd0, grant}, 32'h10);

`ifdef ARB_TIMEOUT_EN
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'h03, 1'b0);
            chk("tmo_hold0", {29'd0, grant_id}, 32'd0);
        end
        step(1'b1, 8'h03, 1'b0);
        chk("tmo_pulse", {31'd0, timeout}, 32'd1);
        chk("tmo_id1", {29'd0, grant_id}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h03, 1'b0);
        chk("tmo_one_cycle", {31'd0, timeout}, 32'd0);
        step(1'b1, 8'h03, 1'b1);
        chk("tmo_done_wins", {31'd0, timeout}, 32'd0);
        chk("tmo_done_id0", {29'd0, grant_id}, 32'd0);
`else
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 24; i++) step(1'b1, 8'h03, 1'b0);
        chk("no_tmo_held", {29'd0, grant_id}, 32'd0);
        chk("no_tmo_pulse", {31'd0, timeout}, 32'd0);
`endif

        // random traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            logic [7:0] r;
            r = 8'($urandom) & ((i % 3 == 0) ? 8'hFF : 8'($urandom));
            step(($urandom_range(0, 60) != 0), r, ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
